// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared FSM encoding and byte-lane constants for the memory access unit
package mem_access_pkg;
   typedef enum logic [2:0] {IDLE, READ, RDATA, WRITE, RESP} stateT;
   localparam int LANE_W = 8;
   localparam int WORD_SHIFT = 2;
endpackage

// File: rtl/byte_lane_merge.sv
// byte_lane_merge: little-endian byte lane extract and insert on a 32-bit word
module byte_lane_merge
   import mem_access_pkg::*;
(
   input  logic [31:0]       wordIn,
   input  logic [1:0]        lane,
   input  logic [LANE_W-1:0] byteIn,
   output logic [LANE_W-1:0] byteOut,
   output logic [31:0]       mergedOut
);
   logic [4:0] shamt;
   assign shamt = 5'(lane * LANE_W);
   always_comb begin
      byteOut = LANE_W'(wordIn >> shamt);
      mergedOut = (wordIn & ~(32'({LANE_W{1'b1}}) << shamt)) | (32'(byteIn) << shamt);
   end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding CPU load/store port onto a word RAM with 1-cycle read
// latency; byte stores are performed as read-modify-write.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int RAM_WORDS = 1024
)(
   input  logic        clock,
   input  logic        reset,
   input  logic        io_req_valid,
   output logic        io_req_ready,
   input  logic        io_req_write,
   input  logic        io_req_byte,
   input  logic [31:0] io_req_addr,
   input  logic [31:0] io_req_wdata,
   output logic        io_resp_valid,
   input  logic        io_resp_ready,
   output logic [31:0] io_resp_rdata,
   output logic        io_resp_fault,
   output logic        io_ram_rEN,
   output logic        io_ram_wEN,
   output logic [31:0] io_ram_addrR,
   output logic [31:0] io_ram_addrW,
   output logic [31:0] io_ram_dataW,
   input  logic [31:0] io_ram_dataR
);
   stateT state, nextState;
   logic isWrite, isByte, faultQ, accept, reqFault;
   logic [1:0] lane;
   logic [31:0] wordAddr, wdataQ, rdataQ, mergedWord, reqWordAddr;
   logic [LANE_W-1:0] laneByte;

   assign accept = io_req_valid && io_req_ready;
   assign reqWordAddr = io_req_addr >> WORD_SHIFT;
   assign reqFault = (!io_req_byte && io_req_addr[1:0] != 2'b00) || reqWordAddr >= 32'(RAM_WORDS);

   byte_lane_merge u_merge (
      .wordIn(io_ram_dataR),
      .lane(lane),
      .byteIn(wdataQ[LANE_W-1:0]),
      .byteOut(laneByte),
      .mergedOut(mergedWord)
   );

   // Datapath registers need no reset: every output that exposes them is gated by state.
   always_ff @(posedge clock)
      if (reset) state <= IDLE;
      else begin
         state <= nextState;
         if (accept) begin
            isWrite <= io_req_write;
            isByte <= io_req_byte;
            wordAddr <= reqWordAddr;
            lane <= io_req_addr[1:0];
            wdataQ <= io_req_wdata;
            rdataQ <= '0;
            faultQ <= reqFault;
         end
         if (state == RDATA && isWrite) wdataQ <= mergedWord;
         if (state == RDATA && !isWrite) rdataQ <= isByte ? 32'(laneByte) : io_ram_dataR;
      end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (accept) nextState = reqFault ? RESP : (io_req_write && !io_req_byte) ? WRITE : READ;
         READ:    nextState = RDATA;
         RDATA:   nextState = isWrite ? WRITE : RESP;
         WRITE:   nextState = RESP;
         RESP:    if (io_resp_ready) nextState = IDLE;
         default: nextState = IDLE;
      endcase
      io_req_ready = state == IDLE;
      io_ram_rEN = state == READ;
      io_ram_wEN = state == WRITE;
      io_ram_addrR = io_ram_rEN ? wordAddr : '0;
      io_ram_addrW = io_ram_wEN ? wordAddr : '0;
      io_ram_dataW = io_ram_wEN ? wdataQ : '0;
      io_resp_valid = state == RESP;
      io_resp_rdata = io_resp_valid ? rdataQ : '0;
      io_resp_fault = io_resp_valid && faultQ;
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized scoreboard bench against a byte-addressed memory model
module tb_mem_access_unit;
   localparam int RW = 256;
   logic clock = 0, reset = 1;
   logic io_req_valid = 0, io_req_write = 0, io_req_byte = 0, io_resp_ready = 0;
   logic [31:0] io_req_addr = 0, io_req_wdata = 0;
   logic io_req_ready, io_resp_valid, io_resp_fault, io_ram_rEN, io_ram_wEN;
   logic [31:0] io_resp_rdata, io_ram_addrR, io_ram_addrW, io_ram_dataW, io_ram_dataR;

   mem_access_unit #(.RAM_WORDS(RW)) dut (
      .clock(clock), .reset(reset),
      .io_req_valid(io_req_valid), .io_req_ready(io_req_ready), .io_req_write(io_req_write),
      .io_req_byte(io_req_byte), .io_req_addr(io_req_addr), .io_req_wdata(io_req_wdata),
      .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
      .io_resp_rdata(io_resp_rdata), .io_resp_fault(io_resp_fault),
      .io_ram_rEN(io_ram_rEN), .io_ram_wEN(io_ram_wEN), .io_ram_addrR(io_ram_addrR),
      .io_ram_addrW(io_ram_addrW), .io_ram_dataW(io_ram_dataW), .io_ram_dataR(io_ram_dataR)
   );

   always #5 clock = ~clock;

   logic [31:0] ramMem [RW];
   logic [31:0] ramQ = 0;
   logic [7:0] refBytes [RW*4];
   assign io_ram_dataR = ramQ;
   always @(posedge clock) begin
      if (io_ram_rEN) ramQ <= io_ram_addrR < RW ? ramMem[int'(io_ram_addrR)] : 32'hDEAD_BEEF;
      if (io_ram_wEN && io_ram_addrW < RW) ramMem[int'(io_ram_addrW)] <= io_ram_dataW;
   end

   typedef struct {
      logic [31:0] rdata, rAddr, wAddr, wData;
      logic fault;
      int lat, rCnt, wCnt;
   } expT;
   expT q[$];
   int checks = 0, failures = 0;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] wordOf(input int wa);
      return {refBytes[4*wa+3], refBytes[4*wa+2], refBytes[4*wa+1], refBytes[4*wa]};
   endfunction

   // Reference: the RAM is a flat byte array; words are four little-endian bytes.
   function automatic expT predict(input bit w, input bit b, input logic [31:0] a, input logic [31:0] d);
      expT e;
      int wa;
      e = '{default: 0};
      wa = int'(a >> 2);
      if ((!b && a % 4 != 0) || wa >= RW) begin
         e.fault = 1;
         e.lat = 1;
      end else if (!w) begin
         e.lat = 3;
         e.rCnt = 1;
         e.rAddr = wa;
         e.rdata = b ? {24'b0, refBytes[int'(a)]} : wordOf(wa);
      end else begin
         if (b) refBytes[int'(a)] = d[7:0];
         else for (int i = 0; i < 4; i++) refBytes[4*wa+i] = d[8*i +: 8];
         e.lat = b ? 4 : 2;
         e.rCnt = b ? 1 : 0;
         e.rAddr = b ? wa : 0;
         e.wCnt = 1;
         e.wAddr = wa;
         e.wData = wordOf(wa);
      end
      return e;
   endfunction

   bit active = 0, startNext = 0, haveResp = 0;
   int lat, rCnt, wCnt;
   logic [31:0] rAddrSeen, wAddrSeen, wDataSeen, heldR;
   logic heldF;
   expT e;

   always @(negedge clock) begin
      if (reset) begin
         active = 0;
         startNext = 0;
      end else begin
         if (startNext) begin
            active = 1; haveResp = 0; lat = 0; rCnt = 0; wCnt = 0;
         end
         chk("reqReady", 32'(io_req_ready), 32'(!active));
         chk("enExclusive", 32'(io_ram_rEN && io_ram_wEN), 0);
         if (!io_ram_rEN) chk("addrRIdle", io_ram_addrR, 0);
         if (!io_ram_wEN) begin
            chk("addrWIdle", io_ram_addrW, 0);
            chk("dataWIdle", io_ram_dataW, 0);
         end
         if (!active) begin
            chk("strayREn", 32'(io_ram_rEN), 0);
            chk("strayWEn", 32'(io_ram_wEN), 0);
            chk("strayResp", 32'(io_resp_valid), 0);
         end else begin
            lat++;
            if (io_ram_rEN) begin rCnt++; rAddrSeen = io_ram_addrR; end
            if (io_ram_wEN) begin wCnt++; wAddrSeen = io_ram_addrW; wDataSeen = io_ram_dataW; end
            if (io_resp_valid) begin
               if (!haveResp) begin
                  chk("scoreboardDepth", 32'(q.size() > 0), 1);
                  if (q.size() > 0) begin
                     e = q.pop_front();
                     chk("rdata", io_resp_rdata, e.rdata);
                     chk("fault", 32'(io_resp_fault), 32'(e.fault));
                     chk("latency", lat, e.lat);
                     chk("rENcount", rCnt, e.rCnt);
                     chk("wENcount", wCnt, e.wCnt);
                     if (e.rCnt > 0 && rCnt > 0) chk("addrR", rAddrSeen, e.rAddr);
                     if (e.wCnt > 0 && wCnt > 0) begin
                        chk("addrW", wAddrSeen, e.wAddr);
                        chk("dataW", wDataSeen, e.wData);
                     end
                  end
                  heldR = io_resp_rdata;
                  heldF = io_resp_fault;
                  haveResp = 1;
               end else begin
                  chk("rdataHold", io_resp_rdata, heldR);
                  chk("faultHold", 32'(io_resp_fault), 32'(heldF));
               end
               if (io_resp_ready) active = 0;
            end
         end
         startNext = io_req_valid && io_req_ready;
      end
   end

   task automatic waitReady();
      int n = 0;
      while (!io_req_ready && n < 50) begin @(posedge clock); #1; n++; end
      chk("readyTimeout", 32'(n < 50), 1);
   endtask

   task automatic issue(input bit w, input bit b, input logic [31:0] a, input logic [31:0] d,
                        input int hold = 0, input bit poke = 0);
      int n;
      waitReady();
      q.push_back(predict(w, b, a, d));
      io_req_valid = 1; io_req_write = w; io_req_byte = b; io_req_addr = a; io_req_wdata = d;
      io_resp_ready = 0;
      @(posedge clock); #1;
      io_req_valid = 0; io_req_write = 1; io_req_addr = 0; io_req_wdata = $urandom;
      n = 0;
      while (!io_resp_valid && n < 20) begin @(posedge clock); #1; n++; end
      chk("respTimeout", 32'(n < 20), 1);
      for (int i = 0; i < hold; i++) begin
         io_req_valid = poke && i == 2;
         @(posedge clock); #1;
      end
      io_req_valid = 0;
      n = 0;
      while (!io_req_ready && n < 50) begin
         io_resp_ready = $urandom_range(0, 2) != 0;
         @(posedge clock); #1; n++;
      end
      chk("handshakeTimeout", 32'(n < 50), 1);
      io_resp_ready = 0;
   endtask

   // Request that is abandoned by a reset k cycles after it is accepted.
   task automatic cancel(input bit w, input logic [31:0] a, input int k);
      waitReady();
      io_req_valid = 1; io_req_write = w; io_req_byte = 1; io_req_addr = a; io_req_wdata = $urandom;
      io_resp_ready = 0;
      @(posedge clock); #1;
      io_req_valid = 0;
      repeat (k) begin @(posedge clock); #1; end
      reset = 1;
      @(posedge clock); #1;
      reset = 0;
      chk("cancelReady", 32'(io_req_ready), 1);
      chk("cancelRespValid", 32'(io_resp_valid), 0);
      chk("cancelWEn", 32'(io_ram_wEN), 0);
   endtask

   bit rw, rb;
   int wi, mism;
   logic [1:0] ln;

   initial begin
      for (int i = 0; i < RW; i++) begin
         ramMem[i] = $urandom;
         if (i == 1) ramMem[i] = 32'h1122_3344;
         for (int j = 0; j < 4; j++) refBytes[4*i+j] = ramMem[i][8*j +: 8];
      end
      @(posedge clock); #1;
      @(posedge clock); #1;
      chk("rstReqReady", 32'(io_req_ready), 1);
      chk("rstRespValid", 32'(io_resp_valid), 0);
      chk("rstRdata", io_resp_rdata, 0);
      chk("rstFault", 32'(io_resp_fault), 0);
      chk("rstREn", 32'(io_ram_rEN), 0);
      chk("rstWEn", 32'(io_ram_wEN), 0);
      chk("rstAddrR", io_ram_addrR, 0);
      chk("rstAddrW", io_ram_addrW, 0);
      chk("rstDataW", io_ram_dataW, 0);
      reset = 0;
      issue(1, 0, 32'h8, 32'h0000_007B);
      issue(0, 0, 32'h8, 0);
      issue(1, 1, 32'h6, 32'h1234_56AA);
      chk("word1Merged", ramMem[1], 32'h11AA_3344);
      issue(0, 1, 32'h6, 0);
      issue(0, 1, 32'h7, 0);
      issue(0, 0, 32'h5, 0);
      issue(1, 0, 32'(4 * RW), 32'hFFFF_FFFF);
      issue(1, 0, 32'h40, 32'h0000_01C8);
      issue(0, 0, 32'h40, 0, 5, 1);
      cancel(1, 32'h8, 1);
      repeat (3) @(posedge clock);
      #1 chk("word2Kept", ramMem[2], 32'h0000_007B);
      cancel(1, 32'h9, 0);
      cancel(0, 32'h40, 2);
      for (int t = 0; t < 80; t++) begin
         rw = 1'($urandom);
         rb = 1'($urandom);
         wi = $urandom_range(0, RW + 3);
         ln = (rb || $urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         if (t % 20 == 19) cancel(0, 32'(4 * (wi % RW)) | 32'(ln), $urandom_range(0, 2));
         else issue(rw, rb, 32'(4 * wi) | 32'(ln), $urandom, $urandom_range(0, 3), 1'($urandom));
      end
      repeat (3) @(posedge clock);
      #1;
      mism = 0;
      for (int i = 0; i < RW; i++) if (ramMem[i] !== wordOf(i)) mism++;
      chk("ramImage", mism, 0);
      chk("pendingAtEnd", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 1024, number of 32-bit words in the attached RAM.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- io_req_valid  in  1  CPU request present.
- io_req_ready  out  1  unit can accept a request.
- io_req_write  in  1  1 = store, 0 = load.
- io_req_byte  in  1  1 = byte access, 0 = word access.
- io_req_addr  in  32  byte address.
- io_req_wdata  in  32  store data; byte stores use bits [7:0].
- io_resp_valid  out  1  response present.
- io_resp_ready  in  1  CPU accepts response.
- io_resp_rdata  out  32  load result; 0 for stores and faults.
- io_resp_fault  out  1  access rejected.
- io_ram_rEN, io_ram_wEN  out  1  RAM read and write enables.
- io_ram_addrR, io_ram_addrW  out  32  RAM word addresses.
- io_ram_dataW  out  32  RAM write data.
- io_ram_dataR  in  32  RAM read data, valid the cycle after rEN is sampled.

Function
REQ-003 SHALL implement FSM states IDLE, READ, RDATA, WRITE, RESP.
REQ-004 IDLE: io_req_ready=1; a request transfers when valid&&ready; SHALL latch write, byte, addr and wdata.
REQ-005 SHALL compute word address = addr[31:2] and lane = addr[1:0], little-endian (lane 0 = bits [7:0]).
REQ-006 Fault when word access has addr[1:0]!=0, or when word address >= RAM_WORDS. Faulting requests SHALL go IDLE->RESP with fault=1 and SHALL NOT assert rEN or wEN.
REQ-007 Next state from IDLE: word store -> WRITE; load or byte store -> READ.
REQ-008 READ: rEN=1 and addrR=word address for exactly one cycle, then RDATA.
REQ-009 RDATA: SHALL capture dataR.
- Word load: rdata=dataR.
- Byte load: rdata = selected lane, zero-extended.
- Loads go to RESP.
- Byte store: SHALL merge wdata[7:0] into the selected lane, keep the other three lanes, then go to WRITE.
REQ-010 WRITE: wEN=1, addrW=word address and dataW=merged or full word for exactly one cycle, then RESP.
REQ-011 RESP: resp_valid=1, with rdata and fault held stable until resp_ready; on resp_valid&&resp_ready go to IDLE.
REQ-012 Latency from accept edge to first resp_valid cycle:
- word load: 3 cycles
- byte load: 3 cycles
- word store: 2 cycles
- byte store: 4 cycles
- fault: 1 cycle
REQ-013 io_req_ready SHALL be 0 in every state but IDLE; a new request SHALL be accepted no earlier than the cycle after the RESP handshake (no back-to-back overlap).
REQ-014 rEN and wEN SHALL never be asserted in the same cycle.
REQ-015 addrR, addrW and dataW SHALL be 0 whenever their enable is 0.
REQ-016 Request inputs SHALL be ignored outside IDLE.

Reset
REQ-017 Reset asserted on any edge SHALL force IDLE; outputs in the following cycle:
- req_ready=1
- resp_valid=0, rdata=0, fault=0
- rEN=0, wEN=0
- addrR=0, addrW=0, dataW=0
REQ-018 Reset in READ or RDATA of a byte store SHALL cancel the store; no wEN is ever issued for it.
REQ-019 Reset in RESP SHALL drop the pending response.

Structure
REQ-020 Package mem_access_pkg SHALL hold:
- the state enum (IDLE, READ, RDATA, WRITE, RESP)
- the lane-width constant (8)
- the word-address shift constant (2)
REQ-021 Lane extract and merge logic SHALL live in one combinational sub-module, byte_lane_merge (inputs: word, lane, byte; outputs: extracted byte, merged word).

Verification
REQ-022 Word store then load: store addr 0x8, data 0x0000007B.
- wEN pulse with addrW=2, dataW=0x7B.
- Load addr 0x8 returns 0x7B with fault=0 three cycles after accept.
REQ-023 Byte store/load: RAM word 1 = 0x11223344; store byte 0xAA to addr 0x6.
- RAM word 1 becomes 0x11AA3344.
- Load byte from addr 0x6 returns 0x000000AA.
- Load byte from addr 0x7 returns 0x00000011.
REQ-024 Unaligned word load from addr 0x5 -> fault=1, rdata=0, no rEN or wEN pulse, resp_valid one cycle after accept.
REQ-025 Out of range: word store to addr 4*RAM_WORDS -> fault=1, no wEN.
REQ-026 Back-pressure: hold resp_ready=0 for 5 cycles after a load of 0x1C8 (456).
- resp_valid and rdata stay stable throughout.
- req_ready stays 0; a req_valid pulse in that window is ignored.
REQ-027 Reset during RDATA of a byte store to addr 0x8 -> next cycle IDLE, req_ready=1, no wEN ever issued, RAM word 2 unchanged.
